// File: rtl/sonic_pkg.sv
// Shared types and constants for the ultrasonic ranger.
package sonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_t;

  localparam int         US_PER_CM = 58;
  localparam logic [8:0] DIST_NONE = 9'h1FF;

  function automatic int ticks_per_us(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-cycle pulse per microsecond of system clock.
module us_tick_gen
  import sonic_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int TPU = ticks_per_us(CLK_HZ);
  localparam int CW  = (TPU > 1) ? $clog2(TPU) : 1;
  localparam logic [CW-1:0] LAST = CW'(TPU - 1);

  logic [CW-1:0] cnt;

  // With a 1 MHz clock LAST is 0 and tick stays high every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sonic_ranger.sv
// HC-SR04 front end: periodic trigger, echo timing in cm (58 us/cm counter,
// no divider), and a debounced, hysteretic obstacle flag.
module sonic_ranger
  import sonic_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25_000,
  parameter int STOP_CM    = 20,
  parameter int RELEASE_CM = 25,
  parameter int STOP_HITS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       echo,
  output logic       trig,
  output logic [8:0] distance_cm,
  output logic       dist_valid,
  output logic       timeout,
  output logic       stop
);

  localparam int PERIOD_US = PERIOD_MS * 1000;
  localparam int FW   = $clog2(PERIOD_US);
  localparam int UMAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int UW   = $clog2(UMAX);
  localparam int SW   = $clog2(US_PER_CM);
  localparam int HW   = $clog2(STOP_HITS + 1);

  localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_US - 1);
  localparam logic [UW-1:0] TRIG_LAST  = UW'(TRIG_US - 1);
  localparam logic [UW-1:0] TO_LAST    = UW'(TIMEOUT_US - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(US_PER_CM - 1);
  localparam logic [HW-1:0] HIT_MAX    = HW'(STOP_HITS);
  localparam logic [8:0]    STOP_D     = 9'(STOP_CM);
  localparam logic [8:0]    REL_D      = 9'(RELEASE_CM);

  if (PERIOD_US <= TRIG_US + 2 * TIMEOUT_US + 2) begin : g_cfg_err
    $error("sonic_ranger: PERIOD_MS too short for TRIG_US + 2*TIMEOUT_US");
  end

  logic tick;

  us_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [1:0] esync;
  logic       eprev;
  logic       rise, fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      esync <= 2'b00;
      eprev <= 1'b0;
    end else begin
      esync <= {esync[0], echo};
      eprev <= esync[1];
    end
  end

  assign rise = esync[1] & ~eprev;
  assign fall = ~esync[1] & eprev;

  logic [FW-1:0] frame;
  logic          wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      frame <= '0;
    else if (tick) frame <= (frame == FRAME_LAST) ? '0 : frame + 1'b1;
  end

  assign wrap = tick && (frame == FRAME_LAST);

  state_t        state;
  logic [UW-1:0] us_cnt;
  logic [SW-1:0] sub;
  logic [8:0]    cm, cm_tick;
  logic          res_to;
  logic [HW-1:0] hit_cnt;

  // The tick landing on the echo fall still counts, so an exact multiple
  // of 58 us reads as the full centimetre.
  always_comb begin
    cm_tick = cm;
    if (tick && sub == SUB_LAST && cm != DIST_NONE) cm_tick = cm + 9'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      trig        <= 1'b0;
      us_cnt      <= '0;
      sub         <= '0;
      cm          <= '0;
      res_to      <= 1'b0;
      hit_cnt     <= '0;
      distance_cm <= DIST_NONE;
      dist_valid  <= 1'b0;
      timeout     <= 1'b0;
      stop        <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: if (wrap) begin
          state  <= TRIG;
          trig   <= 1'b1;
          us_cnt <= '0;
        end
        TRIG: if (tick) begin
          if (us_cnt == TRIG_LAST) begin
            trig   <= 1'b0;
            us_cnt <= '0;
            state  <= WAIT_RISE;
          end else begin
            us_cnt <= us_cnt + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state  <= MEASURE;
            cm     <= '0;
            sub    <= '0;
            us_cnt <= '0;
          end else if (tick) begin
            if (us_cnt == TO_LAST) begin
              cm     <= DIST_NONE;
              res_to <= 1'b1;
              state  <= DONE;
            end else begin
              us_cnt <= us_cnt + 1'b1;
            end
          end
        end
        MEASURE: begin
          if (fall) begin
            cm     <= cm_tick;
            res_to <= 1'b0;
            state  <= DONE;
          end else if (tick) begin
            if (us_cnt == TO_LAST) begin
              cm     <= DIST_NONE;
              res_to <= 1'b1;
              state  <= DONE;
            end else begin
              us_cnt <= us_cnt + 1'b1;
              sub    <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
              cm     <= cm_tick;
            end
          end
        end
        DONE: begin
          distance_cm <= cm;
          dist_valid  <= 1'b1;
          timeout     <= res_to;
          // Between STOP_CM and RELEASE_CM the flag holds: hysteresis band.
          if (cm < STOP_D) begin
            if (hit_cnt != HIT_MAX) hit_cnt <= hit_cnt + 1'b1;
            if (int'(hit_cnt) + 1 >= STOP_HITS) stop <= 1'b1;
          end else if (cm >= REL_D) begin
            hit_cnt <= '0;
            stop    <= 1'b0;
          end else begin
            hit_cnt <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_ranger.sv
// Directed + randomized frames checked against a width/58 distance model
// and a hit-count stop model.
module tb_sonic_ranger;

  localparam int TRIG_US    = 10;
  localparam int PERIOD_US  = 3000;
  localparam int TIMEOUT_US = 1480;
  localparam int STOP_CM    = 20;
  localparam int RELEASE_CM = 25;
  localparam int STOP_HITS  = 2;

  logic       clk, rst, echo;
  logic       trig, dist_valid, timeout, stop;
  logic [8:0] distance_cm;

  int passed = 0;
  int total  = 0;
  int cyc_now = 0;
  int last_rise = -1;
  int hits = 0;
  bit stop_m = 0;

  sonic_ranger #(
    .CLK_HZ(1_000_000), .TRIG_US(TRIG_US), .PERIOD_MS(PERIOD_US / 1000),
    .TIMEOUT_US(TIMEOUT_US), .STOP_CM(STOP_CM), .RELEASE_CM(RELEASE_CM),
    .STOP_HITS(STOP_HITS)
  ) dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .distance_cm(distance_cm),
    .dist_valid(dist_valid), .timeout(timeout), .stop(stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_trig(output int c);
    c = 0;
    while (trig !== 1'b1 && c < 2 * PERIOD_US + 20) begin
      @(posedge clk); #1; c++;
    end
  endtask

  task automatic model_update(input int d);
    if (d < STOP_CM) begin
      if (hits < STOP_HITS) hits++;
      if (hits >= STOP_HITS) stop_m = 1;
    end else if (d >= RELEASE_CM) begin
      hits = 0; stop_m = 0;
    end else begin
      hits = 0;
    end
  endtask

  // One measurement frame: w = echo width in us (0 = no echo); hold keeps
  // echo high from before the trigger.
  task automatic do_frame(input string tag, input int w, input bit hold);
    int c, wt, dly, exp_d;
    bit exp_to, seen;
    if (hold) echo = 1'b1;
    wait_trig(c);
    chk({tag, " trig_seen"}, trig, 1);
    if (last_rise >= 0) chk({tag, " period"}, cyc_now - last_rise, PERIOD_US);
    last_rise = cyc_now;
    wt = 0;
    while (trig === 1'b1 && wt < 100) begin
      @(posedge clk); #1; wt++;
    end
    chk({tag, " trig_width"}, wt, TRIG_US);
    dly = $urandom_range(150, 5);
    c = 0; seen = 0;
    while (!seen && c < 3000) begin
      @(posedge clk); #1; c++;
      if (!hold) echo = (w > 0 && c > dly && c <= dly + w);
      if (dist_valid === 1'b1) seen = 1;
    end
    echo = 1'b0;
    chk({tag, " dv_seen"}, seen, 1);
    if (hold || w == 0 || w >= TIMEOUT_US) begin
      exp_d = 511; exp_to = 1;
    end else begin
      exp_d = w / 58; exp_to = 0;
    end
    model_update(exp_d);
    chk({tag, " distance"}, distance_cm, exp_d);
    chk({tag, " timeout"}, timeout, exp_to);
    chk({tag, " stop"}, stop, stop_m);
    if (w == 0 && !hold)
      chk({tag, " to_latency_ok"}, (c >= TIMEOUT_US - 2 && c <= TIMEOUT_US + 4), 1);
    @(posedge clk); #1;
    chk({tag, " dv_pulse_1cyc"}, dist_valid, 0);
    chk({tag, " to_pulse_1cyc"}, timeout, 0);
  endtask

  initial begin
    int c;
    echo = 1'b0;
    rst  = 1'b1;
    #3 rst = 1'b0;
    #20;
    chk("rst trig", trig, 0);
    chk("rst distance", distance_cm, 9'h1FF);
    chk("rst dist_valid", dist_valid, 0);
    chk("rst timeout", timeout, 0);
    chk("rst stop", stop, 0);
    @(posedge clk); #1 rst = 1'b1;

    wait_trig(c);
    chk("first_trig_after_wrap", (c >= PERIOD_US - 2 && c <= PERIOD_US + 3), 1);

    do_frame("w1160", 1160, 0);
    do_frame("w1102", 1102, 0);
    do_frame("w1160b", 1160, 0);
    do_frame("near1", 580, 0);
    do_frame("near2", 580, 0);
    do_frame("band23", 1334, 0);
    do_frame("rel25", 1450, 0);
    do_frame("near3", 580, 0);
    do_frame("near4", 580, 0);
    do_frame("noecho", 0, 0);
    do_frame("held", 0, 1);
    do_frame("wide", 1600, 0);
    for (int i = 0; i < 2; i++) do_frame("rand", $urandom_range(1470, 60), 0);
    do_frame("near5", 580, 0);
    do_frame("near6", 580, 0);

    // Reset while MEASURE is counting.
    wait_trig(c);
    c = 0;
    while (trig === 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
    repeat (20) @(posedge clk);
    #1 echo = 1'b1;
    repeat (300) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("midrst trig", trig, 0);
    chk("midrst distance", distance_cm, 9'h1FF);
    chk("midrst dist_valid", dist_valid, 0);
    chk("midrst timeout", timeout, 0);
    chk("midrst stop", stop, 0);
    echo = 1'b0;
    hits = 0; stop_m = 0; last_rise = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset while the trigger pulse is high.
    wait_trig(c);
    chk("trig_after_rst_frame", (c >= PERIOD_US - 2 && c <= PERIOD_US + 3), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk("trigrst trig_drops", trig, 0);
    @(posedge clk); #1 rst = 1'b1;

    do_frame("resume", 1160, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
